// File: rtl/t07_pkg.sv
// Shared FSM state type and default geometry for the ESP register-file loader.
package t07_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } esp_state_t;

  localparam int WORD_W_DEF      = 32;
  localparam int FIRST_REG_DEF   = 1;
  localparam int LAST_REG_DEF    = 31;
  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/t07_nibble_assembler.sv
// Packs WORD_W/4 nibbles MSB-first into a word; word/word_ready are valid on the edge that
// captures the last nibble (zero added latency). No backpressure: every nib_vld is consumed.
module t07_nibble_assembler
  import t07_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              nib_vld,
  input  logic [3:0]        nib_dat,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  localparam int NIBS = WORD_W / 4;
  localparam int CW   = $clog2(NIBS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBS - 1);

  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     cnt;

  assign word       = (shreg << 4) | WORD_W'(nib_dat);
  assign word_ready = nib_vld && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (nib_vld) begin
      shreg <= word;
      cnt   <= word_ready ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t07_esp_load_ctrl.sv
// ESP boot loader: nibble stream -> words written to regs FIRST_REG..LAST_REG, write 1 cycle after last nibble.
// ESP is never backpressured; CPU is stalled while a word is in flight. Idle timeout under T07_ESP_TIMEOUT_EN.
module t07_esp_load_ctrl
  import t07_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int FIRST_REG   = FIRST_REG_DEF,
  parameter int LAST_REG    = LAST_REG_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [3:0]        ESP_in,
  input  logic              ESP_valid,
  input  logic              cpu_wr_req,
  output logic              rf_wr_en,
  output logic [4:0]        rf_wr_addr,
  output logic [WORD_W-1:0] rf_wr_data,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              invalError
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  if ((WORD_W % 4) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("t07_esp_load_ctrl: WORD_W must be a multiple of 4 and TIMEOUT_CYC at least 1");
  end

  esp_state_t        state;
  logic [4:0]        ptr;
  logic              busy;
  logic              accept;
  logic              timeout_hit;
  logic              word_ready;
  logic [WORD_W-1:0] word;

  // A nibble landing during the final write has nowhere to go, so it is treated like one in DONE.
  assign accept = ESP_valid && (state != S_DONE) && !((state == S_WRITE) && (ptr == LAST_A));

  t07_nibble_assembler #(
    .WORD_W (WORD_W)
  ) u_asm (
    .clk        (clk),
    .nrst       (nrst),
    .clr        (timeout_hit),
    .nib_vld    (accept),
    .nib_dat    (ESP_in),
    .word       (word),
    .word_ready (word_ready)
  );

`ifdef T07_ESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state == S_COLLECT) && !ESP_valid && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idle_cnt <= '0;
    end else if ((state == S_COLLECT) && !ESP_valid && !timeout_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign rf_wr_addr = ptr;
  // busy already covers the write cycle; the term makes the CPU retry explicit on a collision.
  assign cpu_stall  = busy | (cpu_wr_req & rf_wr_en);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      ptr        <= FIRST_A;
      rf_wr_en   <= 1'b0;
      rf_wr_data <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      invalError <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      if ((state == S_WRITE) && (ptr != LAST_A)) begin
        ptr <= ptr + 5'd1;
      end
      if (word_ready) begin
        state      <= S_WRITE;
        rf_wr_en   <= 1'b1;
        rf_wr_data <= word;
        busy       <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (ESP_valid) begin
              state <= S_COLLECT;
              busy  <= 1'b1;
            end
          end
          S_COLLECT: begin
            if (timeout_hit) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              invalError <= 1'b1;
            end
          end
          S_WRITE: begin
            if (ptr == LAST_A) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              load_done <= 1'b1;
              if (ESP_valid) begin
                invalError <= 1'b1;
              end
            end else if (ESP_valid) begin
              state <= S_COLLECT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_DONE: begin
            if (ESP_valid) begin
              invalError <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t07_esp_load_ctrl.sv
// Self-checking bench for t07_esp_load_ctrl: word-level reference model plus directed literal checks.
module tb_t07_esp_load_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  ESP_in;
  logic        ESP_valid;
  logic        cpu_wr_req;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        cpu_stall;
  logic        load_done;
  logic        invalError;

  always #5 clk = ~clk;

  t07_esp_load_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .ESP_in     (ESP_in),
    .ESP_valid  (ESP_valid),
    .cpu_wr_req (cpu_wr_req),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done),
    .invalError (invalError)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int wr_addr_q[$];

  // Reference model: nibbles collected so far, next register, loader flags.
  int          m_ncnt;
  int          m_reg;
  int          m_idle;
  bit          m_done;
  bit          m_err;
  bit          m_wr;
  logic [31:0] m_acc;
  logic [31:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_ncnt = 0; m_reg = 1; m_idle = 0;
      m_done = 0; m_err = 0; m_wr = 0;
      m_acc = 0; m_data = 0;
    end else begin
      bit was_wr;
      was_wr = m_wr;
      m_wr   = 0;
      if (was_wr) begin
        if (m_reg == 31) m_done = 1;
        else m_reg++;
      end
      if (ESP_valid) begin
        if (m_done) m_err = 1;
        else begin
          m_acc  = {m_acc[27:0], ESP_in};
          m_ncnt++;
          m_idle = 0;
          if (m_ncnt == 8) begin
            m_wr = 1; m_data = m_acc; m_ncnt = 0;
          end
        end
      end
`ifdef T07_ESP_TIMEOUT_EN
      else if (m_ncnt > 0) begin
        m_idle++;
        if (m_idle == 16) begin
          m_ncnt = 0; m_idle = 0; m_err = 1;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_on && nrst) begin
      chk("model.wr_en", 32'(rf_wr_en), 32'(m_wr));
      if (m_wr) chk("model.wr_data", rf_wr_data, m_data);
      chk("model.wr_addr", 32'(rf_wr_addr), 32'(m_reg));
      chk("model.stall", 32'(cpu_stall), 32'((m_ncnt > 0) || m_wr));
      chk("model.load_done", 32'(load_done), 32'(m_done));
      chk("model.invalError", 32'(invalError), 32'(m_err));
      if (rf_wr_en) wr_addr_q.push_back(int'(rf_wr_addr));
    end
  end

  task automatic drive(input bit v, input logic [3:0] n);
    @(posedge clk);
    #2;
    ESP_valid = v;
    ESP_in    = n;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) drive(1'b1, w[i*4 +: 4]);
  endtask

  task automatic settle();
    drive(1'b0, 4'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    ESP_valid = 1'b0;
    nrst      = 1'b0;
    #10;
    nrst      = 1'b1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int base;
    nrst = 1'b1; ESP_in = 4'h0; ESP_valid = 1'b0; cpu_wr_req = 1'b0;
    #1 nrst = 1'b0;
    #2;
    chk("rst.wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst.wr_addr", 32'(rf_wr_addr), 32'd1);
    chk("rst.wr_data", rf_wr_data, 32'd0);
    chk("rst.stall", 32'(cpu_stall), 32'd0);
    chk("rst.load_done", 32'(load_done), 32'd0);
    chk("rst.invalError", 32'(invalError), 32'd0);
    @(posedge clk);
    #2 nrst = 1'b1;
    chk_on = 1'b1;

    // Single word with the CPU hammering on writes throughout.
    cpu_wr_req = 1'b1;
    look();
    chk("a.idle_stall", 32'(cpu_stall), 32'd0);
    drive(1'b1, 4'hA);
    drive(1'b1, 4'hA);
    look();
    chk("a.collect_stall", 32'(cpu_stall), 32'd1);
    drive(1'b1, 4'hB); drive(1'b1, 4'hB);
    drive(1'b1, 4'hC); drive(1'b1, 4'hC);
    drive(1'b1, 4'hD); drive(1'b1, 4'hD);
    settle();
    look();
    chk("a.wr_en", 32'(rf_wr_en), 32'd1);
    chk("a.wr_addr", 32'(rf_wr_addr), 32'd1);
    chk("a.wr_data", rf_wr_data, 32'hAABBCCDD);
    chk("a.write_stall", 32'(cpu_stall), 32'd1);
    chk("a.model_pin", m_data, 32'hAABBCCDD);
    look();
    chk("a.wr_en_drop", 32'(rf_wr_en), 32'd0);
    chk("a.after_stall", 32'(cpu_stall), 32'd0);
    chk("a.next_addr", 32'(rf_wr_addr), 32'd2);
    cpu_wr_req = 1'b0;

    // Full load, 31 words back to back.
    pulse_reset();
    base = wr_addr_q.size();
    repeat (31) send_word(32'hAABBCCDD);
    settle();
    look();
    chk("b.last_wr_en", 32'(rf_wr_en), 32'd1);
    chk("b.last_addr", 32'(rf_wr_addr), 32'd31);
    chk("b.not_done_yet", 32'(load_done), 32'd0);
    look();
    chk("b.load_done", 32'(load_done), 32'd1);
    chk("b.invalError", 32'(invalError), 32'd0);
    chk("b.stall", 32'(cpu_stall), 32'd0);
    chk("b.n_writes", 32'(wr_addr_q.size() - base), 32'd31);
    if (wr_addr_q.size() - base == 31) begin
      chk("b.first_reg", 32'(wr_addr_q[base]), 32'd1);
      chk("b.last_reg", 32'(wr_addr_q[base + 30]), 32'd31);
    end

    // Overflow nibble after the load completed.
    drive(1'b1, 4'h5);
    settle();
    look();
    chk("c.invalError", 32'(invalError), 32'd1);
    chk("c.wr_en", 32'(rf_wr_en), 32'd0);
    chk("c.load_done", 32'(load_done), 32'd1);
    look();
    chk("c.n_writes", 32'(wr_addr_q.size() - base), 32'd31);

    // Reset in the middle of a word.
    pulse_reset();
    look();
    chk("d.err_cleared", 32'(invalError), 32'd0);
    chk("d.done_cleared", 32'(load_done), 32'd0);
    base = wr_addr_q.size();
    repeat (5) drive(1'b1, 4'h9);
    pulse_reset();
    send_word(32'h12345678);
    settle();
    look();
    chk("d.wr_en", 32'(rf_wr_en), 32'd1);
    chk("d.wr_addr", 32'(rf_wr_addr), 32'd1);
    chk("d.wr_data", rf_wr_data, 32'h12345678);
    look();
    chk("d.n_writes", 32'(wr_addr_q.size() - base), 32'd1);

    // Stalled partial word.
    pulse_reset();
    base = wr_addr_q.size();
    repeat (3) drive(1'b1, 4'h7);
`ifdef T07_ESP_TIMEOUT_EN
    repeat (16) drive(1'b0, 4'h0);
    look();
    chk("e.pre_timeout_err", 32'(invalError), 32'd0);
    chk("e.pre_timeout_stall", 32'(cpu_stall), 32'd1);
    drive(1'b0, 4'h0);
    look();
    chk("e.timeout_err", 32'(invalError), 32'd1);
    chk("e.timeout_stall", 32'(cpu_stall), 32'd0);
    send_word(32'h12345678);
    settle();
    look();
    chk("e.wr_en", 32'(rf_wr_en), 32'd1);
    chk("e.wr_addr", 32'(rf_wr_addr), 32'd1);
    chk("e.wr_data", rf_wr_data, 32'h12345678);
`else
    repeat (20) drive(1'b0, 4'h0);
    look();
    chk("e.hold_stall", 32'(cpu_stall), 32'd1);
    chk("e.hold_err", 32'(invalError), 32'd0);
    drive(1'b1, 4'h1); drive(1'b1, 4'h2); drive(1'b1, 4'h3);
    drive(1'b1, 4'h4); drive(1'b1, 4'h5);
    settle();
    look();
    chk("e.wr_en", 32'(rf_wr_en), 32'd1);
    chk("e.wr_addr", 32'(rf_wr_addr), 32'd1);
    chk("e.wr_data", rf_wr_data, 32'h77712345);
`endif
    look();
    chk("e.n_writes", 32'(wr_addr_q.size() - base), 32'd1);

    repeat (2) look();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t07_esp_load_ctrl.md
T07_ESP_LOAD_CTRL -- requirements
Module: t07_esp_load_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, 32, register-file word width; must be a multiple of 4.
REQ-002 SHALL have parameter FIRST_REG, 1, first destination register index (x0 never written).
REQ-003 SHALL have parameter LAST_REG, 31, last destination register index.
REQ-004 SHALL have parameter TIMEOUT_CYC, 16, idle-cycle limit for a partial word (used only under T07_ESP_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  system clock, rising edge.
REQ-006 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port ESP_in  input  4  ESP nibble, MSB-nibble first.
REQ-008 SHALL have port ESP_valid  input  1  ESP_in is sampled on this edge.
REQ-009 SHALL have port cpu_wr_req  input  1  CPU requests a register-file write this cycle.
REQ-010 SHALL have port rf_wr_en  output  1  register-file write strobe (ESP path).
REQ-011 SHALL have port rf_wr_addr  output  5  register-file write index.
REQ-012 SHALL have port rf_wr_data  output  WORD_W  assembled word.
REQ-013 SHALL have port cpu_stall  output  1  CPU must hold its write and freeze.
REQ-014 SHALL have port load_done  output  1  all registers FIRST_REG..LAST_REG loaded.
REQ-015 SHALL have port invalError  output  1  sticky error: overflow or timeout.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-017 SHALL, in IDLE, move to COLLECT on ESP_valid and shift that nibble in as the top nibble.
REQ-018 SHALL, in COLLECT, shift ESP_in into a WORD_W shift register (left shift, new nibble at LSBs) on every ESP_valid cycle; cycles without ESP_valid hold state.
REQ-019 SHALL go to WRITE on the edge that captures nibble WORD_W/4; no nibble is lost if ESP_valid stays high.
REQ-020 SHALL, in WRITE, assert rf_wr_en for exactly one cycle with rf_wr_addr = current pointer and rf_wr_data = assembled word; latency last-nibble-edge to rf_wr_en = 1 cycle.
REQ-021 SHALL accept a nibble arriving during WRITE as nibble 1 of the next word (WRITE -> COLLECT directly).
REQ-022 SHALL increment the pointer after each write; after writing LAST_REG go to DONE.
REQ-023 SHALL hold load_done = 1 in DONE; ESP_valid in DONE sets invalError and data is discarded.
REQ-024 SHALL assert cpu_stall whenever state is COLLECT or WRITE (ESP has priority over CPU writes).
REQ-025 SHALL, when cpu_wr_req and rf_wr_en coincide, keep cpu_stall high that cycle so the CPU retries; the ESP write completes.
REQ-026 SHALL keep invalError set until reset.

Reset
REQ-027 SHALL, on nrst low, asynchronously force state IDLE, pointer FIRST_REG, nibble count 0, shift register 0.
REQ-028 SHALL drive reset outputs: rf_wr_en 0, rf_wr_addr FIRST_REG, rf_wr_data 0, cpu_stall 0, load_done 0, invalError 0.
REQ-029 SHALL, on reset mid-word, discard the partial word with no write issued.

Configuration
REQ-030 SHALL, with T07_ESP_TIMEOUT_EN defined, count consecutive non-valid cycles in COLLECT; reaching TIMEOUT_CYC discards the partial word, sets invalError, returns to IDLE, pointer unchanged.
REQ-031 SHALL, without T07_ESP_TIMEOUT_EN, wait in COLLECT indefinitely and contain no timeout counter.

Structure
REQ-032 SHALL take state enum, WORD_W default and FIRST_REG/LAST_REG defaults from shared package t07_pkg.
REQ-033 SHALL place the nibble shift register and count in one sub-module t07_nibble_assembler (outputs word and word_ready pulse).

Verification
REQ-034 SHALL cover: reset, then nibbles A,A,B,B,C,C,D,D with ESP_valid high 8 cycles -> one-cycle rf_wr_en, rf_wr_addr 1, rf_wr_data 0xAABBCCDD.
REQ-035 SHALL cover: 31 back-to-back words of 0xAABBCCDD -> writes to regs 1..31 in order, load_done 1 one cycle after the reg-31 write, invalError 0.
REQ-036 SHALL cover: one extra nibble after load_done -> invalError 1, no rf_wr_en.
REQ-037 SHALL cover: cpu_wr_req held high throughout a word load -> cpu_stall 1 from first nibble through write cycle, 0 in next IDLE cycle.
REQ-038 SHALL cover: nrst pulsed low after 5 nibbles, then a full word 0x12345678 -> single write to reg 1 with 0x12345678.
REQ-039 SHALL cover (T07_ESP_TIMEOUT_EN): 3 nibbles then 16 idle cycles -> invalError 1, next full word writes reg 1.
